// File: rtl/temporal_conv_mc.sv
// Depthwise multi-channel temporal FIR: round-robin interleaved channels share one serial MAC,
// with runtime-loadable coefficients, dilated taps and round/saturate output scaling.
module temporal_conv_mc #(
   parameter int DATA_WIDTH  = 16,
   parameter int COEF_WIDTH  = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int KERNEL_SIZE = 5,
   parameter int NUM_CH      = 4,
   parameter int DILATION    = 1,
   parameter int OUT_SHIFT   = 15,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TAP_W      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic signed [DATA_WIDTH-1:0] m_data,
   output logic [CH_W-1:0]              m_ch,
   output logic                         m_valid,
   input  logic                         m_ready,
   input  logic                         cfg_we,
   input  logic [CH_W-1:0]              cfg_ch,
   input  logic [TAP_W-1:0]             cfg_tap,
   input  logic signed [COEF_WIDTH-1:0] cfg_data,
   output logic                         cfg_ready,
   output logic                         ovf
);

   localparam int H      = (KERNEL_SIZE - 1) * DILATION + 1;
   localparam int PTR_W  = (H > 1) ? $clog2(H) : 1;
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam logic signed [ACC_WIDTH:0] ROUND = (OUT_SHIFT > 0) ?
      (ACC_WIDTH+1)'(64'sd1 <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state_reg, state_next;

   logic [CH_W-1:0]              ch_reg;
   logic [PTR_W-1:0]             ptr_reg;
   logic [TAP_W-1:0]             tap_reg;
   logic signed [ACC_WIDTH-1:0]  acc_reg;
   logic signed [DATA_WIDTH-1:0] m_data_reg;
   logic [CH_W-1:0]              m_ch_reg;
   logic                         ovf_reg;

   logic                         accept;
   logic                         cfg_hit;
   logic                         last_tap;
   int                           rd_pos;
   logic [PTR_W-1:0]             rd_idx;
   logic signed [DATA_WIDTH-1:0] hist_rd_ch [NUM_CH];
   logic signed [COEF_WIDTH-1:0] coef_rd_ch [NUM_CH];
   logic signed [DATA_WIDTH-1:0] hist_rd;
   logic signed [COEF_WIDTH-1:0] coef_rd;
   logic signed [PROD_W-1:0]     prod;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic signed [ACC_WIDTH:0]    rnd_sum;
   logic signed [ACC_WIDTH:0]    shifted;
   logic signed [DATA_WIDTH-1:0] sat_data;
   logic                         clip;

   assign accept   = (state_reg == IDLE) && s_valid;
   assign cfg_hit  = cfg_we && cfg_ready;
   assign last_tap = (tap_reg == TAP_W'(KERNEL_SIZE - 1));

   // Per-channel history ring and coefficient bank.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic signed [DATA_WIDTH-1:0] hist_mem [H];
         logic signed [COEF_WIDTH-1:0] coef_mem [KERNEL_SIZE];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int j = 0; j < H; j++) hist_mem[j] <= '0;
            end else if (accept && ch_reg == CH_W'(gi)) begin
               hist_mem[ptr_reg] <= s_data;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int j = 0; j < KERNEL_SIZE; j++) coef_mem[j] <= '0;
            end else if (cfg_hit && cfg_ch == CH_W'(gi) && 32'(cfg_tap) < KERNEL_SIZE) begin
               coef_mem[cfg_tap] <= cfg_data;
            end
         end

         assign hist_rd_ch[gi] = hist_mem[rd_idx];
         assign coef_rd_ch[gi] = coef_mem[tap_reg];
      end
   endgenerate

   // Tap offset never exceeds H-1, so a single wrap brings the index back into range.
   always_comb begin
      rd_pos = int'(ptr_reg) - int'(tap_reg) * DILATION;
      if (rd_pos < 0) rd_pos = rd_pos + H;
      rd_idx = PTR_W'(rd_pos);
   end

   assign hist_rd = hist_rd_ch[ch_reg];
   assign coef_rd = coef_rd_ch[ch_reg];
   assign prod    = PROD_W'(hist_rd) * PROD_W'(coef_rd);
   assign acc_sum = acc_reg + ACC_WIDTH'(prod);
   assign rnd_sum = {acc_sum[ACC_WIDTH-1], acc_sum} + ROUND;
   assign shifted = rnd_sum >>> OUT_SHIFT;

   always_comb begin
      clip     = 1'b0;
      sat_data = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         clip     = 1'b1;
         sat_data = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         clip     = 1'b1;
         sat_data = SAT_MIN[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      cfg_ready  = 1'b0;
      m_valid    = 1'b0;
      case (state_reg)
         IDLE: begin
            s_ready   = !rst;
            cfg_ready = !rst;
            if (s_valid) state_next = MAC;
         end
         MAC: begin
            if (last_tap) state_next = OUT;
         end
         OUT: begin
            m_valid = !rst;
            if (m_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_reg     <= '0;
         ptr_reg    <= '0;
         tap_reg    <= '0;
         acc_reg    <= '0;
         m_data_reg <= '0;
         m_ch_reg   <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (s_valid) begin
                  acc_reg <= '0;
                  tap_reg <= '0;
               end
            end
            MAC: begin
               acc_reg <= acc_sum;
               tap_reg <= tap_reg + 1'b1;
               if (last_tap) begin
                  m_data_reg <= sat_data;
                  m_ch_reg   <= ch_reg;
                  if (clip) ovf_reg <= 1'b1;
               end
            end
            OUT: begin
               // The ring pointer is shared, so it only moves once every channel has written.
               if (m_ready) begin
                  if (ch_reg == CH_W'(NUM_CH - 1)) begin
                     ch_reg  <= '0;
                     ptr_reg <= (ptr_reg == PTR_W'(H - 1)) ? '0 : ptr_reg + 1'b1;
                  end else begin
                     ch_reg <= ch_reg + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign m_data = rst ? '0 : m_data_reg;
   assign m_ch   = rst ? '0 : m_ch_reg;
   assign ovf    = ovf_reg & !rst;

endmodule
